// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a req/gnt + rvalid
// handshake, holds the instruction stable for decode, and advances the PC on retire.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pcmux_sel,
    input  logic [31:0] alu_out,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instret,
    output logic        fetch_err
);

    typedef enum logic [1:0] {StFetch, StWait, StIssue, StHalt} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instret_q, instret_d;
    logic        fetch_err_q, fetch_err_d;
    logic [31:0] target;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        instret_d   = instret_q;
        fetch_err_d = fetch_err_q;
        target      = {alu_out[31:1], 1'b0};
        unique case (state_q)
            StFetch: begin
                if (imem_gnt) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    if (imem_err) begin
                        fetch_err_d = 1'b1;
                        state_d     = StHalt;
                    end else begin
                        inst_d  = imem_rdata;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (!stall) begin
                    pc_d      = pcmux_sel ? target : pc_q + 32'd4;
                    instret_d = instret_q + 32'd1;
                    inst_d    = NOP_INST;
                    // A taken target that is not word aligned still retires, then halts.
                    if (pcmux_sel && alu_out[1]) begin
                        fetch_err_d = 1'b1;
                        state_d     = StHalt;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            instret_q   <= 32'd0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            instret_q   <= instret_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign imem_req   = (state_q == StFetch);
    assign imem_addr  = pc_q;
    assign inst_valid = (state_q == StIssue);
    assign inst       = inst_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign instret    = instret_q;
    assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized instruction transactions checked
// against a transaction-level PC / retire-count model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        pcmux_sel;
    logic [31:0] alu_out;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instret;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    // Architectural model: only the next PC and the retire count.
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .pcmux_sel  (pcmux_sel),
        .alu_out    (alu_out),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .imem_err   (imem_err),
        .inst       (inst),
        .inst_valid (inst_valid),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .instret    (instret),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Inputs that must not matter in the current phase.
    task automatic noise();
        stall     = 1'($urandom_range(0, 1));
        pcmux_sel = 1'($urandom_range(0, 1));
        alu_out   = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        noise();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        tick();
        tick();
        rst       = 1'b0;
        m_pc      = 32'h0;
        m_instret = 32'h0;
    endtask

    // One instruction: gd grant delay, rd response delay, sd stall cycles in ISSUE.
    task automatic run_instr(input int gd, input int rd, input int sd, input logic sel,
                             input logic [31:0] tgt, input logic [31:0] word, input logic err);
        logic mis;
        for (int i = 0; i < gd; i++) begin
            chk("req_fetch", 32'(imem_req), 32'd1);
            chk("addr_fetch", imem_addr, m_pc);
            noise();
            imem_gnt    = 1'b0;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
        end
        chk("req_gnt", 32'(imem_req), 32'd1);
        chk("addr_gnt", imem_addr, m_pc);
        chk("valid_fetch", 32'(inst_valid), 32'd0);
        noise();
        imem_gnt    = 1'b1;
        imem_rvalid = 1'($urandom_range(0, 1));
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        for (int i = 0; i < rd; i++) begin
            chk("req_wait", 32'(imem_req), 32'd0);
            chk("valid_wait", 32'(inst_valid), 32'd0);
            noise();
            tick();
        end
        chk("req_rsp", 32'(imem_req), 32'd0);
        noise();
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        imem_err    = err;
        tick();
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        if (err) begin
            chk("err_flag", 32'(fetch_err), 32'd1);
            chk("err_req", 32'(imem_req), 32'd0);
            chk("err_valid", 32'(inst_valid), 32'd0);
            return;
        end
        for (int i = 0; i < sd; i++) begin
            chk("valid_stall", 32'(inst_valid), 32'd1);
            chk("inst_stall", inst, word);
            chk("pc_stall", pc, m_pc);
            chk("pc4_stall", pc_plus4, m_pc + 32'd4);
            chk("instret_stall", instret, m_instret);
            chk("req_stall", 32'(imem_req), 32'd0);
            stall       = 1'b1;
            pcmux_sel   = 1'($urandom_range(0, 1));
            alu_out     = $urandom;
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            tick();
        end
        chk("valid_issue", 32'(inst_valid), 32'd1);
        chk("inst_issue", inst, word);
        chk("pc4_issue", pc_plus4, m_pc + 32'd4);
        stall       = 1'b0;
        pcmux_sel   = sel;
        alu_out     = tgt;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        tick();
        mis       = sel && tgt[1];
        m_pc      = sel ? (tgt & ~32'h1) : m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        chk("pc_retire", pc, m_pc);
        chk("instret_retire", instret, m_instret);
        chk("inst_nop", inst, NOP);
        chk("valid_retire", 32'(inst_valid), 32'd0);
        chk("err_retire", 32'(fetch_err), 32'(mis));
        chk("req_retire", 32'(imem_req), 32'(!mis));
    endtask

    task automatic check_halt(input int n);
        for (int i = 0; i < n; i++) begin
            chk("halt_req", 32'(imem_req), 32'd0);
            chk("halt_valid", 32'(inst_valid), 32'd0);
            chk("halt_err", 32'(fetch_err), 32'd1);
            chk("halt_pc", pc, m_pc);
            noise();
            imem_gnt    = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
    endtask

    initial begin
        imem_rdata = 32'h0;
        do_reset();

        // Reset state
        chk("rst_req", 32'(imem_req), 32'd1);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, NOP);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);

        // Sequential fetch at the 3-cycle minimum
        for (int i = 0; i < 4; i++) begin
            run_instr(0, 0, 0, 1'b0, 32'h0, $urandom, 1'b0);
        end
        chk("seq_instret4", instret, 32'd4);
        chk("seq_addr", imem_addr, 32'h10);

        // Branch taken with bit 0 set in the target
        run_instr(0, 0, 0, 1'b1, 32'h0000_0101, $urandom, 1'b0);
        chk("br_addr", imem_addr, 32'h0000_0100);
        run_instr(0, 0, 1, 1'b0, 32'h0, $urandom, 1'b0);

        // Backpressure: 1+3 fetch, 4 wait, 1+5 issue cycles
        run_instr(3, 3, 5, 1'b0, 32'h0, 32'hCAFE_0013, 1'b0);

        // Randomized traffic with aligned targets
        for (int i = 0; i < 25; i++) begin
            run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      $urandom & ~32'h2, $urandom, 1'b0);
        end

        // PC wrap-around
        run_instr(0, 0, 0, 1'b1, 32'hFFFF_FFFD, $urandom, 1'b0);
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        run_instr(1, 1, 1, 1'b0, 32'h0, $urandom, 1'b0);
        chk("wrap_pc", pc, 32'h0);

        // Misaligned taken target halts after retiring
        run_instr(0, 0, 0, 1'b1, 32'h0000_0006, $urandom, 1'b0);
        check_halt(10);

        // Reset in HALT clears the error
        do_reset();
        chk("halt_rst_err", 32'(fetch_err), 32'd0);
        chk("halt_rst_req", 32'(imem_req), 32'd1);

        // Response error
        run_instr(1, 2, 0, 1'b0, 32'h0, $urandom, 1'b1);
        check_halt(10);
        do_reset();

        // Reset in WAIT coinciding with a response
        run_instr(0, 0, 0, 1'b0, 32'h0, $urandom, 1'b0);
        chk("mid_req", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        rst         = 1'b0;
        imem_rvalid = 1'b0;
        m_pc        = 32'h0;
        m_instret   = 32'h0;
        chk("mid_inst", inst, NOP);
        chk("mid_valid", 32'(inst_valid), 32'd0);
        chk("mid_pc", pc, 32'h0);
        chk("mid_instret", instret, 32'd0);
        run_instr(0, 1, 0, 1'b0, 32'h0, $urandom, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
